// File: rtl/max_pool_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_stream_ctrl
// Description : Streaming 2x2 / stride-2 max-pooling controller for
//               half-precision feature maps. Pixels arrive in raster order
//               (column fastest, then row, then channel). One pooled element
//               is produced per 2x2 window in channel / pooled row / pooled
//               column order.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle pulse that begins a frame (honoured in IDLE only)
//   in_data    in   input pixel (IEEE-754 half bit pattern)
//   in_valid   in   in_data is valid
//   in_ready   out  pixel accepted this cycle when in_valid is also high
//   out_data   out  pooled element
//   out_valid  out  out_data is valid
//   out_ready  in   downstream accepts out_data
//   busy       out  frame in progress (cycle after start until done)
//   done       out  pulse on the handshake of the last pooled element
// ============================================================================
module max_pool_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 28,
  parameter int InputW     = 28,
  parameter int Depth      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  // Column counter is at least 2 bits so that col[COL_W-1:1] is always a
  // legal row-buffer index, even for a 2-pixel-wide map.
  localparam int COL_W     = ($clog2(InputW) < 2) ? 2 : $clog2(InputW);
  localparam int ROW_W     = ($clog2(InputH) < 1) ? 1 : $clog2(InputH);
  localparam int CH_W      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int BUF_DEPTH = 1 << (COL_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [CH_W-1:0]       ch;
  logic [DATA_WIDTH-1:0] pair_reg;
  logic [DATA_WIDTH-1:0] row_buf [BUF_DEPTH];

  logic                  accept;
  logic                  last_col, last_row, last_ch, last_pixel;
  logic [COL_W-2:0]      buf_idx;
  logic [DATA_WIDTH-1:0] pair_max, pool_max;

  // Max of two half-precision patterns. 'first' is the operand received
  // earlier and wins every tie. +0 and -0 count as equal, so the earlier
  // zero is kept. NaN/Inf are ordered purely by sign and magnitude bits.
  function automatic logic [DATA_WIDTH-1:0] half_max(
    input logic [DATA_WIDTH-1:0] first,
    input logic [DATA_WIDTH-1:0] second
  );
    logic [DATA_WIDTH-2:0] mag_f;
    logic [DATA_WIDTH-2:0] mag_s;
    logic                  second_wins;
    mag_f = first[DATA_WIDTH-2:0];
    mag_s = second[DATA_WIDTH-2:0];
    if ((mag_f == '0) && (mag_s == '0)) begin
      second_wins = 1'b0;
    end else if (first[DATA_WIDTH-1] != second[DATA_WIDTH-1]) begin
      second_wins = !second[DATA_WIDTH-1];
    end else if (!first[DATA_WIDTH-1]) begin
      second_wins = (mag_s > mag_f);
    end else begin
      second_wins = (mag_s < mag_f);
    end
    return second_wins ? second : first;
  endfunction

  assign accept     = in_valid && in_ready;
  assign last_col   = (col == COL_W'(InputW - 1));
  assign last_row   = (row == ROW_W'(InputH - 1));
  assign last_ch    = (ch == CH_W'(Depth - 1));
  assign last_pixel = last_col && last_row && last_ch;
  assign buf_idx    = col[COL_W-1:1];

  // Pair max: stored even-column pixel vs. current odd-column pixel.
  // Pool max: the upper row's pair (buffered earlier) vs. this row's pair.
  assign pair_max = half_max(pair_reg, in_data);
  assign pool_max = half_max(row_buf[buf_idx], pair_max);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        // Stall input whenever a pooled element is waiting and cannot leave,
        // so a new load never overwrites an unaccepted output.
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_pixel) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Only the final element can be pending here: every earlier one had
        // to be accepted before the last pixel was let in.
        if (out_valid && out_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Position counters and horizontal pair register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      ch       <= '0;
      pair_reg <= '0;
    end else if ((state == IDLE) && start) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (accept) begin
      if (!col[0]) begin
        pair_reg <= in_data;
      end
      if (last_col) begin
        col <= '0;
        if (last_row) begin
          row <= '0;
          ch  <= last_ch ? '0 : ch + CH_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Row buffer holds upper-row pair maxima; contents need no reset since
  // every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) begin
      row_buf[buf_idx] <= pair_max;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && col[0] && row[0]) begin
      // A load in the same cycle as a handshake replaces the element directly.
      out_valid <= 1'b1;
      out_data  <= pool_max;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_stream_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_max_pool_stream_ctrl
// Description : Self-checking bench for max_pool_stream_ctrl. Instance A is a
//               4x4x1 map, instance B a 4x4x2 map. Expected pooled outputs
//               come from a window-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_stream_ctrl;

  localparam int H = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, busy_a, done_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, busy_b, done_b;
  logic [15:0] out_data_b;

  max_pool_stream_ctrl #(.DATA_WIDTH(16), .InputH(H), .InputW(W), .Depth(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a)
  );

  max_pool_stream_ctrl #(.DATA_WIDTH(16), .InputH(H), .InputW(W), .Depth(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b)
  );

  logic sel;  // 0: observe instance A, 1: observe instance B
  wire        obs_in_ready  = sel ? in_ready_b  : in_ready_a;
  wire        obs_out_valid = sel ? out_valid_b : out_valid_a;
  wire [15:0] obs_out_data  = sel ? out_data_b  : out_data_a;
  wire        obs_busy      = sel ? busy_b      : busy_a;
  wire        obs_done      = sel ? done_b      : done_a;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: map each half pattern onto a signed integer ordering
  // (both zeros map to 0), then per window keep the earliest-arriving element
  // of maximal rank.
  // --------------------------------------------------------------------------
  logic [15:0] pix [64];
  logic [15:0] exp_q [$];

  function automatic int rank(input logic [15:0] h);
    int m;
    m = int'(h[14:0]);
    return h[15] ? -m : m;
  endfunction

  task automatic build_expected(input int depth);
    exp_q.delete();
    for (int c = 0; c < depth; c++) begin
      for (int pr = 0; pr < H / 2; pr++) begin
        for (int pc = 0; pc < W / 2; pc++) begin
          int          base;
          int          order [4];
          logic [15:0] best;
          base     = c * H * W + 2 * pr * W + 2 * pc;
          order[0] = base;
          order[1] = base + 1;
          order[2] = base + W;
          order[3] = base + W + 1;
          best     = pix[order[0]];
          for (int k = 1; k < 4; k++) begin
            if (rank(pix[order[k]]) > rank(best)) best = pix[order[k]];
          end
          exp_q.push_back(best);
        end
      end
    end
  endtask

  // Fill every 2x2 window of a single-channel frame with {a,b ; c,d}.
  task automatic fill_window(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
    for (int r = 0; r < H; r++) begin
      for (int k = 0; k < W; k++) begin
        case ({r[0], k[0]})
          2'b00:   pix[r * W + k] = a;
          2'b01:   pix[r * W + k] = b;
          2'b10:   pix[r * W + k] = c;
          default: pix[r * W + k] = d;
        endcase
      end
    end
  endtask

  // Random values biased toward zeros, infinities, NaN and repeats so ties
  // and special patterns are exercised.
  task automatic fill_random(input int n);
    logic [15:0] specials [8];
    specials = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00,
                 16'h7C00, 16'hFC00, 16'h7E00, 16'hFE00};
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(2) == 0) pix[i] = specials[$urandom_range(7)];
      else                        pix[i] = 16'($urandom);
    end
  endtask

  task automatic set_start(input logic which, input logic v);
    if (which) start_b = v;
    else       start_a = v;
  endtask

  // Runs one frame on the selected instance. Inputs are driven at the falling
  // edge and outputs sampled 1 ns later, so each recorded handshake is the one
  // the next rising edge will perform.
  task automatic run_frame(input logic which, input int depth, input int valid_pct,
                           input int ready_pct, input bit hold_mode,
                           input int abort_at, input bit poke_start);
    int          npix;
    int          acc      = 0;
    int          got      = 0;
    int          dones    = 0;
    int          cycles   = 0;
    int          hold_cnt = 0;
    bit          seen     = 0;
    bit          fin      = 0;
    logic [15:0] held     = '0;

    sel  = which;
    npix = H * W * depth;
    build_expected(depth);

    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    check("busy_after_start", obs_busy, 1);

    while (!fin && cycles < 3000) begin
      in_valid = (acc < npix) && ($urandom_range(99) < valid_pct);
      in_data  = in_valid ? pix[acc] : 16'($urandom);
      if (poke_start) set_start(which, $urandom_range(7) == 0);
      out_ready = hold_mode ? (seen && hold_cnt >= 5) : ($urandom_range(99) < ready_pct);
      #1;
      if (hold_mode && seen && hold_cnt < 5) begin
        check("hold_out_data", obs_out_data, held);
        check("hold_out_valid", obs_out_valid, 1);
        check("hold_in_ready", obs_in_ready, 0);
        hold_cnt++;
      end
      if (hold_mode && !seen && obs_out_valid) begin
        seen = 1;
        held = obs_out_data;
      end
      if (in_valid && obs_in_ready) acc++;
      if (obs_out_valid && out_ready) begin
        if (got < exp_q.size()) check($sformatf("out%0d", got), obs_out_data, exp_q[got]);
        got++;
      end
      if (obs_done) begin
        dones++;
        fin = 1;
      end
      if (abort_at > 0 && acc == abort_at) fin = 1;
      cycles++;
      @(negedge clk);
    end
    set_start(which, 1'b0);
    in_valid = 1'b0;

    if (abort_at == 0) begin
      check("frame_timeout", cycles < 3000, 1);
      check("out_count", got, exp_q.size());
      check("done_count", dones, 1);
      check("in_handshakes", acc, npix);
      check("busy_after_done", obs_busy, 0);
      check("done_after_done", obs_done, 0);
      check("in_ready_idle", obs_in_ready, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    sel       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_out_valid", out_valid_b, 0);
    reset = 1'b0;

    // Pixels offered in IDLE are not consumed.
    in_valid  = 1'b1;
    in_data   = 16'h4000;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("idle_in_ready", in_ready_a, 0);
    check("idle_busy", busy_a, 0);
    in_valid = 1'b0;

    // Alternating-row pattern, all windows pool to 4500.
    fill_window(16'h4000, 16'h4400, 16'h4500, 16'h4200);
    run_frame(1'b0, 1, 100, 100, 0, 0, 0);

    // All-negative windows.
    fill_window(16'hC400, 16'hC000, 16'hC200, 16'hC500);
    run_frame(1'b0, 1, 100, 100, 0, 0, 0);

    // Signed-zero ties: earliest zero wins.
    fill_window(16'h8000, 16'h0000, 16'h8000, 16'h0000);
    run_frame(1'b0, 1, 100, 100, 0, 0, 0);
    fill_window(16'h0000, 16'h8000, 16'h0000, 16'h8000);
    run_frame(1'b0, 1, 100, 100, 0, 0, 0);

    // Downstream stall after the first output.
    fill_random(H * W);
    run_frame(1'b0, 1, 100, 100, 1, 0, 0);

    // Random data with random valid/ready and stray start pulses mid-frame.
    repeat (4) begin
      fill_random(H * W);
      run_frame(1'b0, 1, 70, 60, 0, 0, 1);
    end

    // Reset after seven accepted pixels, then a clean frame.
    fill_random(H * W);
    run_frame(1'b0, 1, 100, 100, 0, 7, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", out_valid_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_in_ready", in_ready_a, 0);
    check("abort_done", done_a, 0);
    fill_random(H * W);
    run_frame(1'b0, 1, 90, 90, 0, 0, 0);

    // Two-channel frame: constant channels, then random.
    for (int i = 0; i < H * W; i++) begin
      pix[i]         = 16'h3C00;
      pix[H * W + i] = 16'h4000;
    end
    run_frame(1'b1, 2, 100, 100, 0, 0, 0);
    fill_random(2 * H * W);
    run_frame(1'b1, 2, 80, 70, 0, 0, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
